// File: rtl/adder_mux_unit.sv
// Registered leaf block: 1-bit full adder, ADD_W-bit ripple-carry adder and 4:1 bit mux.
// Optional macro ADD_OVF_EN adds a registered signed-overflow flag (add_ovf) for the ripple adder.
module adder_mux_unit #(
    parameter int unsigned ADD_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fa_a,
    input  logic             fa_b,
    input  logic             fa_cin,
    output logic             fa_sum,
    output logic             fa_cout,
    input  logic [ADD_W-1:0] add_x,
    input  logic [ADD_W-1:0] add_y,
    input  logic             add_cin,
    output logic [ADD_W-1:0] add_sum,
    output logic             add_cout,
`ifdef ADD_OVF_EN
    output logic             add_ovf,
`endif
    input  logic             mux_a,
    input  logic             mux_b,
    input  logic             mux_c,
    input  logic             mux_d,
    input  logic [1:0]       mux_sel,
    output logic             mux_out
);

    logic             fa_sum_c;
    logic             fa_cout_c;
    logic [ADD_W-1:0] add_sum_c;
    logic             add_cout_c;
    logic             msb_cin_c;
    logic             mux_out_c;

    // Standalone full-adder cell
    always_comb begin
        fa_sum_c  = fa_a ^ fa_b ^ fa_cin;
        fa_cout_c = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));
    end

    // Ripple chain; the carry is walked as a scalar so the chain stays a plain combinational path
    always_comb begin
        logic carry;
        add_sum_c = '0;
        msb_cin_c = 1'b0;
        carry     = add_cin;
        for (int unsigned i = 0; i < ADD_W; i++) begin
            msb_cin_c    = carry;
            add_sum_c[i] = add_x[i] ^ add_y[i] ^ carry;
            carry        = (add_x[i] & add_y[i]) | (carry & (add_x[i] ^ add_y[i]));
        end
        add_cout_c = carry;
    end

    always_comb begin
        mux_out_c = 1'b0;
        case (mux_sel)
            2'b00:   mux_out_c = mux_a;
            2'b01:   mux_out_c = mux_b;
            2'b10:   mux_out_c = mux_c;
            default: mux_out_c = mux_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fa_sum   <= 1'b0;
            fa_cout  <= 1'b0;
            add_sum  <= '0;
            add_cout <= 1'b0;
            mux_out  <= 1'b0;
        end else begin
            fa_sum   <= fa_sum_c;
            fa_cout  <= fa_cout_c;
            add_sum  <= add_sum_c;
            add_cout <= add_cout_c;
            mux_out  <= mux_out_c;
        end
    end

`ifdef ADD_OVF_EN
    // Signed overflow: carry into the MSB cell disagrees with carry out of it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            add_ovf <= 1'b0;
        end else begin
            add_ovf <= msb_cin_c ^ add_cout_c;
        end
    end
`endif

endmodule

// File: tb/tb_adder_mux_unit.sv
// Self-checking bench for adder_mux_unit against an arithmetic reference model.
module tb_adder_mux_unit;

    localparam int unsigned ADD_W = 2;
`ifdef ADD_OVF_EN
    localparam int unsigned OW = ADD_W + 5;
`else
    localparam int unsigned OW = ADD_W + 4;
`endif

    logic             clk;
    logic             rst_n;
    logic             fa_a, fa_b, fa_cin;
    logic             fa_sum, fa_cout;
    logic [ADD_W-1:0] add_x, add_y;
    logic             add_cin;
    logic [ADD_W-1:0] add_sum;
    logic             add_cout;
    logic             mux_a, mux_b, mux_c, mux_d;
    logic [1:0]       mux_sel;
    logic             mux_out;
`ifdef ADD_OVF_EN
    logic             add_ovf;
`endif
    logic [OW-1:0]    obs;

    int checks = 0;
    int errors = 0;

    adder_mux_unit #(.ADD_W(ADD_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
        .fa_sum(fa_sum), .fa_cout(fa_cout),
        .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
`ifdef ADD_OVF_EN
        .add_ovf(add_ovf),
`endif
        .mux_a(mux_a), .mux_b(mux_b), .mux_c(mux_c), .mux_d(mux_d),
        .mux_sel(mux_sel), .mux_out(mux_out)
    );

`ifdef ADD_OVF_EN
    assign obs = {fa_cout, fa_sum, add_cout, add_sum, mux_out, add_ovf};
`else
    assign obs = {fa_cout, fa_sum, add_cout, add_sum, mux_out};
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected register contents after the next edge, from the inputs currently applied
    function automatic logic [OW-1:0] model(input logic rst_val);
        int ones;
        int total;
        int half;
        int sx;
        int sy;
        int s;
        logic [3:0] m;
        logic [1:0] fa_v;
        logic [ADD_W:0] add_v;
        logic ovf;
        if (!rst_val) return '0;
        ones  = int'(fa_a) + int'(fa_b) + int'(fa_cin);
        fa_v  = 2'(ones);
        total = int'(add_x) + int'(add_y) + int'(add_cin);
        add_v = (ADD_W+1)'(total);
        m     = {mux_d, mux_c, mux_b, mux_a};
        half  = 1 << (ADD_W - 1);
        sx    = int'(add_x);
        sy    = int'(add_y);
        if (sx >= half) sx = sx - 2 * half;
        if (sy >= half) sy = sy - 2 * half;
        s     = sx + sy + int'(add_cin);
        ovf   = (s >= half) || (s < -half);
`ifdef ADD_OVF_EN
        return {fa_v, add_v, m[mux_sel], ovf};
`else
        if (ovf) ones = ones + 0;
        return {fa_v, add_v, m[mux_sel]};
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        fa_a    = 1'($urandom);
        fa_b    = 1'($urandom);
        fa_cin  = 1'($urandom);
        add_x   = ADD_W'($urandom);
        add_y   = ADD_W'($urandom);
        add_cin = 1'($urandom);
        mux_a   = 1'($urandom);
        mux_b   = 1'($urandom);
        mux_c   = 1'($urandom);
        mux_d   = 1'($urandom);
        mux_sel = 2'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fa_a = 1'b1; fa_b = 1'b1; fa_cin = 1'b1;
        add_x = '1; add_y = '1; add_cin = 1'b1;
        mux_a = 1'b1; mux_b = 1'b1; mux_c = 1'b1; mux_d = 1'b1; mux_sel = 2'b11;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %b want 0", i, obs);
            end
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({fa_cout, fa_sum, add_cout, add_sum, mux_out} !== 6'b111111) begin
            errors++;
            $display("FAIL reset_release: got %b want 111111",
                     {fa_cout, fa_sum, add_cout, add_sum, mux_out});
        end
    endtask

    task automatic test_full_adder();
        logic [2:0] v;
        logic [1:0] want;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {fa_a, fa_b, fa_cin} = v;
            want = 2'($countones(v));
            tick();
            checks++;
            if ({fa_cout, fa_sum} !== want) begin
                errors++;
                $display("FAIL full_adder abc=%b: got %b want %b", v, {fa_cout, fa_sum}, want);
            end
        end
    endtask

    task automatic test_ripple_directed();
        logic [1:0] xs [4] = '{2'd0, 2'd0, 2'd1, 2'd3};
        logic [1:0] ys [4] = '{2'd0, 2'd3, 2'd1, 2'd3};
        logic [2:0] ws [4] = '{3'b001, 3'b100, 3'b011, 3'b111};
        for (int i = 0; i < 4; i++) begin
            add_x = xs[i]; add_y = ys[i]; add_cin = 1'b1;
            tick();
            checks++;
            if ({add_cout, add_sum} !== ws[i]) begin
                errors++;
                $display("FAIL ripple_directed x=%0d y=%0d: got %b want %b",
                         xs[i], ys[i], {add_cout, add_sum}, ws[i]);
            end
        end
    endtask

    task automatic test_ripple_sweep();
        logic [ADD_W:0] want;
        for (int x = 0; x < (1 << ADD_W); x++)
            for (int y = 0; y < (1 << ADD_W); y++)
                for (int c = 0; c < 2; c++) begin
                    add_x = ADD_W'(x); add_y = ADD_W'(y); add_cin = 1'(c);
                    want = (ADD_W+1)'(x + y + c);
                    tick();
                    checks++;
                    if ({add_cout, add_sum} !== want) begin
                        errors++;
                        $display("FAIL ripple_sweep x=%0d y=%0d c=%0d: got %b want %b",
                                 x, y, c, {add_cout, add_sum}, want);
                    end
                end
    endtask

    task automatic test_mux();
        logic [3:0] m;
        for (int pol = 0; pol < 2; pol++)
            for (int s = 0; s < 4; s++) begin
                m = 4'(1 << s);
                if (pol == 1) m = ~m;
                {mux_d, mux_c, mux_b, mux_a} = m;
                mux_sel = 2'(s);
                tick();
                checks++;
                if (mux_out !== (pol == 0)) begin
                    errors++;
                    $display("FAIL mux_walk sel=%0d data=%b: got %b want %b",
                             s, m, mux_out, pol == 0);
                end
            end
    endtask

    task automatic test_stream();
        logic [OW-1:0] want;
        for (int i = 0; i < 40; i++) begin
            rand_inputs();
            rst_n = (i == 20) ? 1'b0 : 1'b1;
            want = model(rst_n);
            tick();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL stream cycle %0d rst_n=%b: got %b want %b", i, rst_n, obs, want);
            end
        end
        rst_n = 1'b1;
    endtask

`ifdef ADD_OVF_EN
    task automatic test_ovf();
        logic [1:0] xs [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        logic [1:0] ys [4] = '{2'b01, 2'b11, 2'b10, 2'b01};
        logic       ws [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            add_x = xs[i]; add_y = ys[i]; add_cin = 1'b0;
            tick();
            checks++;
            if (add_ovf !== ws[i]) begin
                errors++;
                $display("FAIL add_ovf x=%b y=%b: got %b want %b", xs[i], ys[i], add_ovf, ws[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_adder();
        test_ripple_directed();
        test_ripple_sweep();
        test_mux();
        test_stream();
`ifdef ADD_OVF_EN
        test_ovf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
